lifo_arbiter: RTL and testbench
===============================

Name: lifo_arbiter

Overview:
Shares one lifo instance between NREQ requesters, each issuing push or pop transactions over a valid/ready handshake. Round-robin arbitration, at most one LIFO operation per cycle. Tracks occupancy locally so full/empty decisions never lag the LIFO flags. Also sequences LIFO clearing after reset and on flush.

Parameters:
NREQ, 2, number of requesters (2..8)
DWIDTH, 8, data width; matches the lifo DWIDTH
AWIDTH, 3, lifo address width; depth DEPTH = 2**AWIDTH

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  one-cycle request to clear the LIFO
req_valid_i  in  NREQ  per-requester transaction valid
req_op_i  in  NREQ  per-requester op: 0 = push, 1 = pop
req_data_i  in  NREQ*DWIDTH  push data; requester k in bits [k*DWIDTH +: DWIDTH]
req_ready_o  out  NREQ  one-hot grant; transfer when valid & ready
rsp_valid_o  out  NREQ  one-hot pop-data strobe to the popping requester
rsp_data_o  out  DWIDTH  pop data, shared bus, qualified by rsp_valid_o
count_o  out  AWIDTH+1  local occupancy
lifo_srst_o  out  1  to lifo srst_i
lifo_wrreq_o  out  1  to lifo wrreq_i
lifo_rdreq_o  out  1  to lifo rdreq_i
lifo_data_o  out  DWIDTH  to lifo data_i
lifo_q_i  in  DWIDTH  from lifo q_o; valid the cycle after lifo_rdreq_o

Behaviour:
- Reset (arst_n_i low): all outputs 0 except lifo_srst_o = 1. State INIT, count 0, RR pointer = NREQ-1, so requester 0 has first priority.
- States:
  - INIT: lifo_srst_o = 1 for exactly one cycle after reset release, no grants, then RUN.
  - RUN: normal arbitration.
  - FLUSH: lifo_srst_o = 1 for one cycle, no grants, count <= 0, then RUN.
- flush_i sampled high in RUN -> FLUSH next cycle. flush_i is ignored in INIT and FLUSH.
- Eligibility of requester k:
  - req_valid_i[k] must be high.
  - Push: count < DEPTH.
  - Pop: count > 0.
  - Ineligible requesters are skipped, not stalled by others.
- Grant: in RUN, combinational round-robin search from pointer+1 (mod NREQ) for the first eligible requester.
  - req_ready_o is one-hot or zero.
  - req_ready_o depends combinationally on req_valid_i/req_op_i; requesters must not make valid depend on ready.
  - In the cycle flush_i is high, no grant is issued.
- On grant to k:
  - Pointer <= k.
  - Push: lifo_wrreq_o = 1, lifo_data_o = req_data_i slice k (same cycle, combinational), count +1.
  - Pop: lifo_rdreq_o = 1, count -1.
  - lifo_wrreq_o and lifo_rdreq_o are never both 1.
- Pop response: one cycle after a pop grant to k, rsp_valid_o[k] = 1 and rsp_data_o = lifo_q_i.
  - Pipelined: back-to-back pops deliver back-to-back responses.
  - rsp_data_o holds its last value when no strobe is active.
- A pop granted in the cycle before flush_i still delivers its response during FLUSH.
- count never exceeds DEPTH and never wraps below 0; count_o is registered.
- Reset asserted mid-operation: a pending response is dropped and count clears. The LIFO is cleared via INIT.
- No grants while lifo_srst_o = 1.

Decomposition:
- Package lifo_arb_pkg:
  - state enum {INIT, RUN, FLUSH}
  - op constants OP_PUSH = 1'b0, OP_POP = 1'b1
- Sub-module rr_arbiter (NREQ): inputs eligible vector and pointer; outputs one-hot grant and grant index.
- Top-level lifo_arbiter holds the FSM, count, response pipeline and LIFO drive.

Test Plan (NREQ=2, DWIDTH=8, AWIDTH=3, with lifo instance):
1. Reset release -> lifo_srst_o high exactly 1 cycle, req_ready_o = 0 that cycle, count_o = 0, then grants enabled.
2. Both push every cycle (r0 data 0x10.., r1 data 0x20..) -> grants alternate 0,1,0,1; after 8 grants count_o = 8 and ready stays 0 for pushes while pops are still granted.
3. Push 0xA1, 0xB2, 0xC3 from r0, then r1 pops 3 back-to-back -> rsp_valid_o[1] on 3 consecutive cycles with data 0xC3, 0xB2, 0xA1; count_o = 0.
4. count 0, r0 pops and r1 pushes 0x55 -> r0 skipped, r1 granted; next cycle r0 granted; r0 gets rsp 0x55.
5. count 5, pop granted at cycle t, flush_i at t+1 -> response still delivered at t+1, lifo_srst_o at t+2, no grant at t+1..t+2, count_o = 0.
6. arst_n_i pulsed low mid-stream with count 4 -> all outputs reset; after release INIT clears the LIFO; a subsequent pop is not granted (count 0).

Source files
------------

// File: rtl/lifo_arb_pkg.sv
// rtl/lifo_arb_pkg.sv - shared state and op encodings for the LIFO arbiter
package lifo_arb_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting one past the pointer
module rr_arbiter
   import lifo_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] eligible_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IW-1:0]   idx_o
);

   logic          found;
   logic [IW-1:0] cand;

   // Walk NREQ candidates in rotated order; the pointer itself is tried last.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = IW'((int'(ptr_i) + i) % NREQ);
         if (!found && eligible_i[cand]) begin
            found          = 1'b1;
            grant_o[cand]  = 1'b1;
            idx_o          = cand;
         end
      end
   end

endmodule

// File: rtl/lifo_arbiter.sv
// rtl/lifo_arbiter.sv - round-robin sharing of one LIFO between NREQ push/pop requesters
module lifo_arbiter
   import lifo_arb_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 3
) (
   input  logic                   clk_i,
   input  logic                   arst_n_i,
   input  logic                   flush_i,
   input  logic [NREQ-1:0]        req_valid_i,
   input  logic [NREQ-1:0]        req_op_i,
   input  logic [NREQ*DWIDTH-1:0] req_data_i,
   output logic [NREQ-1:0]        req_ready_o,
   output logic [NREQ-1:0]        rsp_valid_o,
   output logic [DWIDTH-1:0]      rsp_data_o,
   output logic [AWIDTH:0]        count_o,
   output logic                   lifo_srst_o,
   output logic                   lifo_wrreq_o,
   output logic                   lifo_rdreq_o,
   output logic [DWIDTH-1:0]      lifo_data_o,
   input  logic [DWIDTH-1:0]      lifo_q_i
);

   localparam int              IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [AWIDTH:0] DEPTH   = (AWIDTH+1)'(2**AWIDTH);
   localparam logic [IW-1:0]   PTR_RST = IW'(NREQ-1);

   state_e            state_q;
   logic [AWIDTH:0]   count_q;
   logic [AWIDTH:0]   count_d;
   logic [IW-1:0]     ptr_q;
   logic              srst_q;
   logic [NREQ-1:0]   rsp_pend_q;
   logic [DWIDTH-1:0] rsp_hold_q;

   logic              grant_en;
   logic [NREQ-1:0]   elig;
   logic [NREQ-1:0]   gnt;
   logic [IW-1:0]     gnt_idx;
   logic              gnt_any;
   logic              gnt_pop;
   logic [DWIDTH-1:0] push_data;

   // Eligibility uses the local count so full/empty never lags the LIFO flags.
   always_comb begin
      grant_en = (state_q == RUN) && !flush_i && !srst_q;
      elig     = '0;
      for (int k = 0; k < NREQ; k++) begin
         elig[k] = grant_en && req_valid_i[k] &&
                   ((req_op_i[k] == OP_PUSH) ? (count_q < DEPTH) : (count_q != '0));
      end
   end

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr (
      .eligible_i (elig),
      .ptr_i      (ptr_q),
      .grant_o    (gnt),
      .idx_o      (gnt_idx)
   );

   always_comb begin
      push_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (k == int'(gnt_idx)) begin
            push_data = req_data_i[k*DWIDTH +: DWIDTH];
         end
      end
   end

   assign gnt_any      = |gnt;
   assign gnt_pop      = gnt_any && (req_op_i[gnt_idx] == OP_POP);
   assign req_ready_o  = gnt;
   assign lifo_wrreq_o = gnt_any && !gnt_pop;
   assign lifo_rdreq_o = gnt_pop;
   assign lifo_data_o  = lifo_wrreq_o ? push_data : '0;
   assign lifo_srst_o  = srst_q;
   assign count_o      = count_q;
   assign rsp_valid_o  = rsp_pend_q;
   assign rsp_data_o   = (|rsp_pend_q) ? lifo_q_i : rsp_hold_q;

   always_comb begin
      count_d = count_q;
      if (lifo_wrreq_o) begin
         count_d = count_q + 1'b1;
      end else if (lifo_rdreq_o) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q    <= INIT;
         count_q    <= '0;
         ptr_q      <= PTR_RST;
         srst_q     <= 1'b1;
         rsp_pend_q <= '0;
         rsp_hold_q <= '0;
      end else begin
         rsp_pend_q <= gnt_pop ? gnt : '0;
         if (|rsp_pend_q) begin
            rsp_hold_q <= lifo_q_i;
         end
         if (gnt_any) begin
            ptr_q <= gnt_idx;
         end
         case (state_q)
            INIT: begin
               state_q <= RUN;
               srst_q  <= 1'b0;
            end
            RUN: begin
               if (flush_i) begin
                  state_q <= FLUSH;
                  srst_q  <= 1'b1;
                  count_q <= '0;
               end else begin
                  count_q <= count_d;
               end
            end
            FLUSH: begin
               state_q <= RUN;
               srst_q  <= 1'b0;
            end
            default: begin
               state_q <= INIT;
               srst_q  <= 1'b1;
               count_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lifo_arbiter.sv
// tb/tb_lifo_arbiter.sv - directed self-checking bench for lifo_arbiter with a behavioural LIFO
module tb_lifo_arbiter;

   logic        clk;
   logic        arst_n;
   logic        flush;
   logic [1:0]  vld;
   logic [1:0]  op;
   logic [15:0] rdata;
   logic [1:0]  ready;
   logic [1:0]  rsp_vld;
   logic [7:0]  rsp_data;
   logic [3:0]  count;
   logic        srst;
   logic        wr;
   logic        rd;
   logic [7:0]  din;
   logic [7:0]  lq;

   logic [7:0]  mem [8];
   logic [3:0]  sp;

   int n_chk  = 0;
   int n_pass = 0;

   lifo_arbiter #(
      .NREQ   (2),
      .DWIDTH (8),
      .AWIDTH (3)
   ) dut (
      .clk_i        (clk),
      .arst_n_i     (arst_n),
      .flush_i      (flush),
      .req_valid_i  (vld),
      .req_op_i     (op),
      .req_data_i   (rdata),
      .req_ready_o  (ready),
      .rsp_valid_o  (rsp_vld),
      .rsp_data_o   (rsp_data),
      .count_o      (count),
      .lifo_srst_o  (srst),
      .lifo_wrreq_o (wr),
      .lifo_rdreq_o (rd),
      .lifo_data_o  (din),
      .lifo_q_i     (lq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial lq = '0;
   always @(posedge clk) begin
      if (srst) begin
         sp <= '0;
      end else if (wr) begin
         mem[sp[2:0]] <= din;
         sp           <= sp + 4'd1;
      end else if (rd) begin
         lq <= mem[sp[2:0] - 3'd1];
         sp <= sp - 4'd1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One bench cycle: inputs change just after the rising edge, checks follow at the falling edge.
   task automatic cyc(input logic [1:0] v, input logic [1:0] o,
                      input logic [7:0] a, input logic [7:0] b, input logic f);
      @(posedge clk);
      #1;
      vld   = v;
      op    = o;
      rdata = {b, a};
      flush = f;
      @(negedge clk);
   endtask

   initial begin
      arst_n = 1'b0;
      flush  = 1'b0;
      vld    = '0;
      op     = '0;
      rdata  = '0;

      // 1: reset and INIT
      cyc(2'b11, 2'b00, 8'h01, 8'h02, 1'b0);
      cyc(2'b11, 2'b00, 8'h01, 8'h02, 1'b0);
      check("rst_srst", srst, 1);
      check("rst_ready", ready, 0);
      check("rst_count", count, 0);
      check("rst_rsp", rsp_vld, 0);
      check("rst_wr", wr, 0);
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      @(negedge clk);
      check("init_srst", srst, 1);
      check("init_ready", ready, 0);

      // 2: alternating pushes until full, then pop still granted
      for (int i = 0; i < 8; i++) begin
         cyc(2'b11, 2'b00, 8'h10 + 8'(i), 8'h20 + 8'(i), 1'b0);
         check("push_ready", ready, (i % 2 == 0) ? 2'b01 : 2'b10);
         check("push_data", din, (i % 2 == 0) ? 8'h10 + 8'(i) : 8'h20 + 8'(i));
         if (i == 0) check("run_srst", srst, 0);
      end
      cyc(2'b11, 2'b00, 8'h18, 8'h28, 1'b0);
      check("full_count", count, 8);
      check("full_ready", ready, 0);
      cyc(2'b11, 2'b10, 8'h19, 8'h00, 1'b0);
      check("full_pop_ready", ready, 2'b10);
      check("full_pop_rd", rd, 1);
      check("full_pop_wr", wr, 0);
      cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
      check("full_pop_rspv", rsp_vld, 2'b10);
      check("full_pop_rspd", rsp_data, 8'h27);
      check("flush_cyc_ready", ready, 0);
      cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
      check("flush1_srst", srst, 1);
      check("flush1_count", count, 0);

      // 3: three pushes then three back-to-back pops
      cyc(2'b01, 2'b00, 8'hA1, 8'h00, 1'b0);
      check("t3_srst", srst, 0);
      check("t3_ready0", ready, 2'b01);
      cyc(2'b01, 2'b00, 8'hB2, 8'h00, 1'b0);
      cyc(2'b01, 2'b00, 8'hC3, 8'h00, 1'b0);
      check("t3_count3", count, 2);
      cyc(2'b10, 2'b10, 8'h00, 8'h00, 1'b0);
      check("t3_pop1_ready", ready, 2'b10);
      check("t3_pop1_rspv", rsp_vld, 0);
      cyc(2'b10, 2'b10, 8'h00, 8'h00, 1'b0);
      check("t3_rsp1v", rsp_vld, 2'b10);
      check("t3_rsp1d", rsp_data, 8'hC3);
      cyc(2'b10, 2'b10, 8'h00, 8'h00, 1'b0);
      check("t3_rsp2v", rsp_vld, 2'b10);
      check("t3_rsp2d", rsp_data, 8'hB2);
      cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
      check("t3_rsp3v", rsp_vld, 2'b10);
      check("t3_rsp3d", rsp_data, 8'hA1);
      check("t3_count0", count, 0);

      // 4: empty pop skipped in favour of a push
      cyc(2'b11, 2'b01, 8'h00, 8'h55, 1'b0);
      check("t4_ready_r1", ready, 2'b10);
      check("t4_data", din, 8'h55);
      cyc(2'b01, 2'b01, 8'h00, 8'h00, 1'b0);
      check("t4_ready_r0", ready, 2'b01);
      check("t4_count1", count, 1);
      cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
      check("t4_rspv", rsp_vld, 2'b01);
      check("t4_rspd", rsp_data, 8'h55);
      cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
      check("t4_hold_v", rsp_vld, 0);
      check("t4_hold_d", rsp_data, 8'h55);

      // 5: pop then flush on the next cycle
      for (int i = 0; i < 5; i++) cyc(2'b01, 2'b00, 8'h60 + 8'(i), 8'h00, 1'b0);
      cyc(2'b10, 2'b10, 8'h00, 8'h00, 1'b0);
      check("t5_count5", count, 5);
      check("t5_pop_ready", ready, 2'b10);
      cyc(2'b11, 2'b11, 8'h00, 8'h00, 1'b1);
      check("t5_flush_ready", ready, 0);
      check("t5_rspv", rsp_vld, 2'b10);
      check("t5_rspd", rsp_data, 8'h64);
      check("t5_count4", count, 4);
      cyc(2'b11, 2'b11, 8'h00, 8'h00, 1'b0);
      check("t5_srst", srst, 1);
      check("t5_srst_ready", ready, 0);
      check("t5_count0", count, 0);
      check("t5_rspv_off", rsp_vld, 0);
      cyc(2'b11, 2'b11, 8'h00, 8'h00, 1'b0);
      check("t5_srst_off", srst, 0);
      check("t5_empty_ready", ready, 0);

      // 6: asynchronous reset mid-stream
      for (int i = 0; i < 4; i++) cyc(2'b01, 2'b00, 8'h70 + 8'(i), 8'h00, 1'b0);
      cyc(2'b10, 2'b10, 8'h00, 8'h00, 1'b0);
      check("t6_count4", count, 4);
      check("t6_pop_ready", ready, 2'b10);
      @(posedge clk);
      #1;
      arst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_rspv", rsp_vld, 0);
      check("t6_rst_rspd", rsp_data, 0);
      check("t6_rst_count", count, 0);
      check("t6_rst_srst", srst, 1);
      check("t6_rst_ready", ready, 0);
      check("t6_rst_rd", rd, 0);
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      @(negedge clk);
      check("t6_init_srst", srst, 1);
      check("t6_init_ready", ready, 0);
      cyc(2'b10, 2'b10, 8'h00, 8'h00, 1'b0);
      check("t6_run_srst", srst, 0);
      check("t6_empty_pop", ready, 0);
      check("t6_count0", count, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
